// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC and IF/ID register controller: steers fetch from the predictor and recovers on EX/MEM mispredicts.
// Optional BRANCH_STATS_EN adds resolved-branch and mispredict counters.
module fetch_redirect_ctrl #(
   parameter int unsigned              DATA_WIDTH = 32,
   parameter int unsigned              IDX_W      = 3,
   parameter logic [DATA_WIDTH-1:0]    RESET_PC   = 'h0040_0000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_stall,
   input  logic [DATA_WIDTH-1:0] i_imem_instr,
   output logic [DATA_WIDTH-1:0] o_pc,
   output logic [DATA_WIDTH-1:0] o_if_id_instr,
   output logic [DATA_WIDTH-1:0] o_if_id_pc,
   output logic                  o_if_id_valid,
   output logic [6:0]            o_if_id_opcode,
   output logic [IDX_W-1:0]      o_pred_idx,
   input  logic                  i_prediction,
   input  logic [DATA_WIDTH-1:0] i_pred_target,
   output logic                  o_if_id_pred_taken,
   output logic [DATA_WIDTH-1:0] o_if_id_pred_target,
   input  logic                  i_exm_branch,
   input  logic                  i_exm_taken,
   input  logic [DATA_WIDTH-1:0] i_exm_target,
   input  logic [DATA_WIDTH-1:0] i_exm_pc,
   input  logic                  i_exm_pred_taken,
   input  logic [DATA_WIDTH-1:0] i_exm_pred_target,
   output logic                  o_flush
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]           o_branch_cnt,
   output logic [31:0]           o_mispred_cnt
`endif
);

   localparam logic [6:0]            OPC_BRANCH = 7'b1100011;
   localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013);

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
   logic [DATA_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
   logic                  if_id_valid_q, if_id_valid_d;
   // Side register: prediction of the branch that just redirected, shown the cycle after.
   logic                  pred_taken_q, pred_taken_d;
   logic [DATA_WIDTH-1:0] pred_target_q, pred_target_d;

   logic                  pred_redir;
   logic                  mispredict;
   logic [DATA_WIDTH-1:0] recovery_pc;

   always_comb begin
      pred_redir  = if_id_valid_q & (if_id_instr_q[6:0] == OPC_BRANCH) & i_prediction;
      mispredict  = i_exm_branch &
                    ((i_exm_taken != i_exm_pred_taken) |
                     (i_exm_taken & (i_exm_target != i_exm_pred_target)));
      o_flush     = ~i_rst & mispredict;
      recovery_pc = i_exm_taken ? i_exm_target : i_exm_pc + DATA_WIDTH'(4);
   end

   always_comb begin
      pc_d          = pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_valid_d = if_id_valid_q;
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      if (o_flush) begin
         pc_d          = recovery_pc;
         if_id_instr_d = NOP_INSTR;
         if_id_pc_d    = '0;
         if_id_valid_d = 1'b0;
         pred_taken_d  = 1'b0;
         pred_target_d = '0;
      end else if (i_stall) begin
         pc_d = pc_q;
      end else if (pred_redir) begin
         pc_d          = i_pred_target;
         if_id_instr_d = NOP_INSTR;
         if_id_pc_d    = '0;
         if_id_valid_d = 1'b0;
         pred_taken_d  = 1'b1;
         pred_target_d = i_pred_target;
      end else begin
         pc_d          = pc_q + DATA_WIDTH'(4);
         if_id_instr_d = i_imem_instr;
         if_id_pc_d    = pc_q;
         if_id_valid_d = 1'b1;
         pred_taken_d  = 1'b0;
         pred_target_d = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q          <= RESET_PC;
         if_id_instr_q <= NOP_INSTR;
         if_id_pc_q    <= '0;
         if_id_valid_q <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else begin
         pc_q          <= pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_valid_q <= if_id_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
      end
   end

   always_comb begin
      o_pc                = pc_q;
      o_if_id_instr       = if_id_instr_q;
      o_if_id_pc          = if_id_pc_q;
      o_if_id_valid       = if_id_valid_q;
      o_if_id_opcode      = if_id_instr_q[6:0];
      o_pred_idx          = if_id_pc_q[IDX_W+1:2];
      o_if_id_pred_taken  = pred_taken_q;
      o_if_id_pred_target = pred_target_q;
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] branch_cnt_q, mispred_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (i_exm_branch) branch_cnt_q  <= branch_cnt_q + 32'd1;
         if (o_flush)      mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   always_comb begin
      o_branch_cnt  = branch_cnt_q;
      o_mispred_cnt = mispred_cnt_q;
   end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios then random traffic against a rule-level fetch model.
// Counter outputs are checked when BRANCH_STATS_EN is defined.
module tb_fetch_redirect_ctrl;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] BEQ    = 32'h0020_8463;

   logic        clk = 1'b0;
   logic        i_rst, i_stall, i_prediction;
   logic [31:0] i_imem_instr, i_pred_target;
   logic        i_exm_branch, i_exm_taken, i_exm_pred_taken;
   logic [31:0] i_exm_target, i_exm_pc, i_exm_pred_target;
   logic [31:0] o_pc, o_if_id_instr, o_if_id_pc, o_if_id_pred_target;
   logic        o_if_id_valid, o_if_id_pred_taken, o_flush;
   logic [6:0]  o_if_id_opcode;
   logic [2:0]  o_pred_idx;
`ifdef BRANCH_STATS_EN
   logic [31:0] o_branch_cnt, o_mispred_cnt;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference fetch state, advanced by the priority rules of the controller.
   logic [31:0] m_pc, m_instr, m_ifpc, m_ptarget;
   logic        m_valid, m_ptaken;
   logic [31:0] m_br, m_mis;

   always #5 clk = ~clk;

   fetch_redirect_ctrl #(.DATA_WIDTH(32), .IDX_W(3), .RESET_PC(RST_PC)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_imem_instr(i_imem_instr),
      .o_pc(o_pc), .o_if_id_instr(o_if_id_instr), .o_if_id_pc(o_if_id_pc),
      .o_if_id_valid(o_if_id_valid), .o_if_id_opcode(o_if_id_opcode), .o_pred_idx(o_pred_idx),
      .i_prediction(i_prediction), .i_pred_target(i_pred_target),
      .o_if_id_pred_taken(o_if_id_pred_taken), .o_if_id_pred_target(o_if_id_pred_target),
      .i_exm_branch(i_exm_branch), .i_exm_taken(i_exm_taken), .i_exm_target(i_exm_target),
      .i_exm_pc(i_exm_pc), .i_exm_pred_taken(i_exm_pred_taken),
      .i_exm_pred_target(i_exm_pred_target), .o_flush(o_flush)
`ifdef BRANCH_STATS_EN
      , .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_instr = NOP; m_ifpc = '0; m_valid = 1'b0;
      m_ptaken = 1'b0; m_ptarget = '0; m_br = '0; m_mis = '0;
   endtask

   task automatic check_state();
      chk("pc", o_pc, m_pc);
      chk("if_instr", o_if_id_instr, m_instr);
      chk("if_pc", o_if_id_pc, m_ifpc);
      chk("if_valid", 32'(o_if_id_valid), 32'(m_valid));
      chk("opcode", 32'(o_if_id_opcode), 32'(m_instr[6:0]));
      chk("pred_idx", 32'(o_pred_idx), 32'(m_ifpc[4:2]));
      chk("pred_taken", 32'(o_if_id_pred_taken), 32'(m_ptaken));
      chk("pred_target", o_if_id_pred_target, m_ptarget);
`ifdef BRANCH_STATS_EN
      chk("branch_cnt", o_branch_cnt, m_br);
      chk("mispred_cnt", o_mispred_cnt, m_mis);
`endif
   endtask

   task automatic clear_exm();
      i_exm_branch = 1'b0; i_exm_taken = 1'b0; i_exm_target = '0; i_exm_pc = '0;
      i_exm_pred_taken = 1'b0; i_exm_pred_target = '0;
   endtask

   // One clock: check combinational flush, step the model, check registered state.
   task automatic cycle();
      logic        exp_flush, redir;
      logic [31:0] rec;
      exp_flush = i_exm_branch && ((i_exm_taken != i_exm_pred_taken) ||
                                   (i_exm_taken && (i_exm_target != i_exm_pred_target)));
      #1;
      chk("flush", 32'(o_flush), 32'(exp_flush));
      redir = m_valid && (m_instr[6:0] == 7'h63) && i_prediction;
      rec   = i_exm_taken ? i_exm_target : i_exm_pc + 32'd4;
      if (i_exm_branch) m_br = m_br + 32'd1;
      if (exp_flush) m_mis = m_mis + 32'd1;
      @(posedge clk);
      #1;
      if (exp_flush) begin
         m_pc = rec; m_instr = NOP; m_ifpc = '0; m_valid = 1'b0; m_ptaken = 1'b0; m_ptarget = '0;
      end else if (i_stall) begin
         m_pc = m_pc;
      end else if (redir) begin
         m_pc = i_pred_target; m_instr = NOP; m_ifpc = '0; m_valid = 1'b0;
         m_ptaken = 1'b1; m_ptarget = i_pred_target;
      end else begin
         m_ifpc = m_pc; m_instr = i_imem_instr; m_valid = 1'b1;
         m_pc = m_pc + 32'd4; m_ptaken = 1'b0; m_ptarget = '0;
      end
      check_state();
   endtask

   task automatic rand_inputs();
      logic [31:0] r;
      r            = $urandom();
      i_imem_instr = ($urandom_range(0, 1) == 1) ? {r[31:7], 7'h63} : r;
      i_stall      = ($urandom_range(0, 3) == 0);
      i_prediction = $urandom_range(0, 1) == 1;
      i_pred_target = {$urandom(), 2'b00} >> 2 << 2;
      i_exm_branch = ($urandom_range(0, 2) == 0);
      i_exm_taken  = $urandom_range(0, 1) == 1;
      i_exm_target = $urandom() & 32'hFFFF_FFFC;
      i_exm_pc     = $urandom() & 32'hFFFF_FFFC;
      i_exm_pred_taken  = ($urandom_range(0, 1) == 1) ? i_exm_taken : ~i_exm_taken;
      i_exm_pred_target = ($urandom_range(0, 3) != 0) ? i_exm_target : ($urandom() & 32'hFFFF_FFFC);
   endtask

   initial begin
      i_rst = 1'b1; i_stall = 1'b0; i_prediction = 1'b0; i_pred_target = '0;
      i_imem_instr = NOP;
      clear_exm();
      model_reset();
      #12;
      check_state();
      // Mispredict presented during reset must not flush.
      i_exm_branch = 1'b1; i_exm_taken = 1'b1; i_exm_target = 32'h0040_0100;
      #1;
      chk("flush_in_reset", 32'(o_flush), 32'd0);
      clear_exm();
      i_rst = 1'b0;

      // Sequential fetch after release.
      i_imem_instr = 32'h0010_0093;
      cycle();
      chk("seq_pc1", o_pc, 32'h0040_0004);
      chk("seq_valid", 32'(o_if_id_valid), 32'd1);
      i_imem_instr = 32'h0020_0113;
      cycle();
      chk("seq_pc2", o_pc, 32'h0040_0008);

      // Predicted-taken BEQ at 0x00400008.
      i_imem_instr = BEQ;
      cycle();
      chk("beq_ifpc", o_if_id_pc, 32'h0040_0008);
      i_prediction = 1'b1; i_pred_target = 32'h0040_0040;
      cycle();
      chk("redir_pc", o_pc, 32'h0040_0040);
      chk("redir_bubble", o_if_id_instr, NOP);
      chk("redir_side_tgt", o_if_id_pred_target, 32'h0040_0040);
      i_prediction = 1'b0; i_imem_instr = 32'h0000_0033;
      cycle();

      // Mispredict: actually taken, predicted not taken.
      i_exm_branch = 1'b1; i_exm_taken = 1'b1; i_exm_target = 32'h0040_0100;
      cycle();
      chk("flush_taken_pc", o_pc, 32'h0040_0100);
      // Mispredict: actually not taken, predicted taken.
      i_exm_taken = 1'b0; i_exm_pred_taken = 1'b1; i_exm_pc = 32'h0040_0020;
      i_exm_pred_target = 32'h0040_0300;
      cycle();
      chk("flush_nt_pc", o_pc, 32'h0040_0024);
      // Both taken, targets differ.
      i_exm_taken = 1'b1; i_exm_target = 32'h0040_0500; i_exm_pred_target = 32'h0040_0504;
      cycle();
      // Correct prediction: no flush.
      i_exm_pred_target = 32'h0040_0500;
      cycle();
      // Recovery PC wraps.
      i_exm_taken = 1'b0; i_exm_pred_taken = 1'b1; i_exm_pc = 32'hFFFF_FFFC;
      cycle();
      chk("wrap_pc", o_pc, 32'h0000_0000);
      clear_exm();

      // Stall three cycles, then flush while still stalled.
      i_imem_instr = 32'h0030_0193;
      cycle();
      i_stall = 1'b1;
      repeat (3) cycle();
      i_exm_branch = 1'b1; i_exm_taken = 1'b1; i_exm_target = 32'h0040_0700;
      cycle();
      chk("stall_flush_pc", o_pc, 32'h0040_0700);
      clear_exm(); i_stall = 1'b0;

      // Flush beats a simultaneous predicted redirect.
      i_imem_instr = BEQ;
      cycle();
      i_prediction = 1'b1; i_pred_target = 32'h0040_0900;
      i_exm_branch = 1'b1; i_exm_taken = 1'b1; i_exm_target = 32'h0040_0A00;
      cycle();
      chk("flush_wins_pc", o_pc, 32'h0040_0A00);
      clear_exm(); i_prediction = 1'b0;

      // Random traffic with one asynchronous reset in the middle.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            i_rst = 1'b1;
            #1;
            model_reset();
            check_state();
            i_rst = 1'b0;
         end
         rand_inputs();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
